fpga_tdpram_pipe: RTL

- Single-clock true dual-port RAM for the AXI URAM memory subsystem.
- Generalises the per-byte-lane dual-port SRAM array with:
  - parametrised data, lane and address widths;
  - selectable 1- or 2-cycle registered read latency with valid strobes;
  - same-port write mode (read-first or write-first);
  - defined same-address cross-port arbitration with a collision flag;
  - a reset-triggered zero-fill sequencer.
- Sits between the AXI slave datapath and the FPGA memory primitives.

---
 rtl/fpga_tdpram_pipe.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/fpga_tdpram_pipe.sv
// Single-clock true dual-port RAM with byte-lane writes, 1/2-cycle
// registered reads, same-address cross-port arbitration and zero-fill.
//
// Ports:
//   clk, rst            : shared clock, synchronous active-high reset
//   ena/enb             : port access request
//   wea/web             : per-byte-lane write enables
//   addra/addrb         : word address
//   dina/dinb           : write data
//   douta/doutb         : read data (held while the valid is low)
//   douta_vld/doutb_vld : one-cycle read-data valid pulse
//   init_busy           : zero-fill in progress, requests are dropped
//   collision           : pulse on a same-address, same-lane dual write
module fpga_tdpram_pipe #(
    parameter int DATA_WIDTH    = 64,
    parameter int BYTE_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 10,
    parameter int RD_LATENCY    = 1,
    parameter int WRITE_MODE    = 0,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               ena,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   wea,
    input  logic [ADDR_WIDTH-1:0]              addra,
    input  logic [DATA_WIDTH-1:0]              dina,
    output logic [DATA_WIDTH-1:0]              douta,
    output logic                               douta_vld,
    input  logic                               enb,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   web,
    input  logic [ADDR_WIDTH-1:0]              addrb,
    input  logic [DATA_WIDTH-1:0]              dinb,
    output logic [DATA_WIDTH-1:0]              doutb,
    output logic                               doutb_vld,
    output logic                               init_busy,
    output logic                               collision
);

    localparam int NBYTE = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    generate
        if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
            $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
        end
        if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
            $error("RD_LATENCY must be 1 or 2");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    fill_we;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    acc_a, acc_b;
    logic                    same_addr;
    logic [NBYTE-1:0]        wr_a, wr_b;
    logic [DATA_WIDTH-1:0]   old_a, old_b;
    logic [DATA_WIDTH-1:0]   rd_a, rd_b;

    logic [DATA_WIDTH-1:0]   s1_dout_a_q, s1_dout_a_d;
    logic [DATA_WIDTH-1:0]   s1_dout_b_q, s1_dout_b_d;
    logic                    s1_vld_a_q, s1_vld_a_d;
    logic                    s1_vld_b_q, s1_vld_b_d;
    logic [DATA_WIDTH-1:0]   s2_dout_a_q, s2_dout_a_d;
    logic [DATA_WIDTH-1:0]   s2_dout_b_q, s2_dout_b_d;
    logic                    s2_vld_a_q, s2_vld_a_d;
    logic                    s2_vld_b_q, s2_vld_b_d;
    logic                    col_q, col_d;

    // Zero-fill sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_we = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            FILL: begin
                fill_we = 1'b1;
                cnt_d   = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == '1) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            if (INIT_ON_RESET != 0) begin
                state_q <= FILL;
            end else begin
                state_q <= IDLE;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign init_busy = (state_q == FILL);

    // Request acceptance and lane arbitration
    assign acc_a     = ena & ~init_busy & ~rst;
    assign acc_b     = enb & ~init_busy & ~rst;
    assign same_addr = (addra == addrb);
    assign wr_a      = {NBYTE{acc_a}} & wea;
    // Port A owns any lane both ports write at the same address
    assign wr_b      = {NBYTE{acc_b}} & web & ~(same_addr ? wr_a : '0);

    assign old_a = mem[addra];
    assign old_b = mem[addrb];

    // Write-first merges only the port's own data; the other port's
    // write in the same cycle is never visible to this port's read.
    always_comb begin
        rd_a = old_a;
        rd_b = old_b;
        if (WRITE_MODE == 1) begin
            for (int k = 0; k < NBYTE; k++) begin
                if (wr_a[k]) begin
                    rd_a[k*BYTE_WIDTH +: BYTE_WIDTH] =
                        dina[k*BYTE_WIDTH +: BYTE_WIDTH];
                end
                if (acc_b && web[k]) begin
                    rd_b[k*BYTE_WIDTH +: BYTE_WIDTH] =
                        dinb[k*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // RAM array: no reset, contents only change by fill or writes
    always_ff @(posedge clk) begin
        if (fill_we && !rst) begin
            mem[cnt_q] <= '0;
        end
        for (int k = 0; k < NBYTE; k++) begin
            if (wr_a[k]) begin
                mem[addra][k*BYTE_WIDTH +: BYTE_WIDTH] <=
                    dina[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
            if (wr_b[k]) begin
                mem[addrb][k*BYTE_WIDTH +: BYTE_WIDTH] <=
                    dinb[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Read pipeline: data registers hold while no valid passes through
    always_comb begin
        s1_vld_a_d  = acc_a;
        s1_vld_b_d  = acc_b;
        s1_dout_a_d = acc_a ? rd_a : s1_dout_a_q;
        s1_dout_b_d = acc_b ? rd_b : s1_dout_b_q;
        s2_vld_a_d  = s1_vld_a_q;
        s2_vld_b_d  = s1_vld_b_q;
        s2_dout_a_d = s1_vld_a_q ? s1_dout_a_q : s2_dout_a_q;
        s2_dout_b_d = s1_vld_b_q ? s1_dout_b_q : s2_dout_b_q;
        col_d       = acc_a & acc_b & same_addr & (|(wea & web));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_dout_a_q <= '0;
            s1_dout_b_q <= '0;
            s1_vld_a_q  <= 1'b0;
            s1_vld_b_q  <= 1'b0;
            s2_dout_a_q <= '0;
            s2_dout_b_q <= '0;
            s2_vld_a_q  <= 1'b0;
            s2_vld_b_q  <= 1'b0;
            col_q       <= 1'b0;
        end else begin
            s1_dout_a_q <= s1_dout_a_d;
            s1_dout_b_q <= s1_dout_b_d;
            s1_vld_a_q  <= s1_vld_a_d;
            s1_vld_b_q  <= s1_vld_b_d;
            s2_dout_a_q <= s2_dout_a_d;
            s2_dout_b_q <= s2_dout_b_d;
            s2_vld_a_q  <= s2_vld_a_d;
            s2_vld_b_q  <= s2_vld_b_d;
            col_q       <= col_d;
        end
    end

    assign douta     = (RD_LATENCY == 2) ? s2_dout_a_q : s1_dout_a_q;
    assign doutb     = (RD_LATENCY == 2) ? s2_dout_b_q : s1_dout_b_q;
    assign douta_vld = (RD_LATENCY == 2) ? s2_vld_a_q  : s1_vld_a_q;
    assign doutb_vld = (RD_LATENCY == 2) ? s2_vld_b_q  : s1_vld_b_q;
    assign collision = col_q;

endmodule
